// File: rtl/mac_result_unloader_if.sv
// Output stream of the MAC result unloader: DATA_WIDTH-bit chunks with a
// valid/ready handshake toward the host byte path.
interface mac_result_unloader_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  o_ready;

  modport master (
    output o_data,
    output o_valid,
    input  o_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    output o_ready
  );
endinterface

// File: rtl/mac_result_unloader.sv
// Drain side of the MAC array: snapshots all row results on start, streams
// them out MS chunk first, then pulses mac_clr and done.
module mac_result_unloader #(
  parameter int NUM_ROWS   = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ACC_WIDTH-1:0] res_in [NUM_ROWS-1:0],
  mac_result_unloader_if.master out_bus,
  output logic                 busy,
  output logic                 mac_clr,
  output logic                 done
);

  localparam int CHUNKS  = ACC_WIDTH / DATA_WIDTH;
  localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  state_r;
  logic [ACC_WIDTH-1:0]    snap_r [NUM_ROWS-1:0];
  logic [ROW_W-1:0]        row_r;
  logic [CHUNK_W-1:0]      chunk_r;
  logic [DATA_WIDTH-1:0]   o_data_r;
  logic                    o_valid_r;
  logic                    busy_r;
  logic                    mac_clr_r;
  logic                    done_r;

  logic                    xfer_s;
  logic                    last_chunk_s;
  logic                    last_row_s;
  logic [ROW_W-1:0]        nxt_row_s;
  logic [CHUNK_W-1:0]      nxt_chunk_s;

  // Chunk idx of a result word, counted from the most significant end.
  function automatic logic [DATA_WIDTH-1:0] chunk_sel(
    input logic [ACC_WIDTH-1:0] word,
    input logic [CHUNK_W-1:0]   idx
  );
    logic [ACC_WIDTH-1:0] shifted;
    shifted = word >> ((CHUNKS - 1 - int'(idx)) * DATA_WIDTH);
    return shifted[DATA_WIDTH-1:0];
  endfunction

  assign out_bus.o_data  = o_data_r;
  assign out_bus.o_valid = o_valid_r;
  assign busy            = busy_r;
  assign mac_clr         = mac_clr_r;
  assign done            = done_r;

  // Handshake decode and row/chunk advance for the next transfer.
  always_comb begin
    xfer_s       = o_valid_r & out_bus.o_ready;
    last_chunk_s = (chunk_r == CHUNK_W'(CHUNKS - 1));
    last_row_s   = (row_r == ROW_W'(NUM_ROWS - 1));
    nxt_row_s    = row_r;
    nxt_chunk_s  = chunk_r;
    if (last_chunk_s) begin
      nxt_chunk_s = '0;
      nxt_row_s   = row_r + ROW_W'(1);
    end else begin
      nxt_chunk_s = chunk_r + CHUNK_W'(1);
      nxt_row_s   = row_r;
    end
  end

  // Unloader FSM with registered stream and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      row_r     <= '0;
      chunk_r   <= '0;
      o_data_r  <= '0;
      o_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      mac_clr_r <= 1'b0;
      done_r    <= 1'b0;
      for (int i = 0; i < NUM_ROWS; i++) begin
        snap_r[i] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          mac_clr_r <= 1'b0;
          done_r    <= 1'b0;
          if (start) begin
            // First chunk comes straight from res_in: snap_r is written on this same edge.
            for (int i = 0; i < NUM_ROWS; i++) begin
              snap_r[i] <= res_in[i];
            end
            row_r     <= '0;
            chunk_r   <= '0;
            o_data_r  <= chunk_sel(res_in[0], CHUNK_W'(0));
            o_valid_r <= 1'b1;
            busy_r    <= 1'b1;
            state_r   <= ST_SEND;
          end else begin
            o_data_r  <= '0;
            o_valid_r <= 1'b0;
            busy_r    <= 1'b0;
          end
        end
        ST_SEND: begin
          if (xfer_s) begin
            if (last_row_s && last_chunk_s) begin
              row_r     <= '0;
              chunk_r   <= '0;
              o_data_r  <= '0;
              o_valid_r <= 1'b0;
              mac_clr_r <= 1'b1;
              state_r   <= ST_CLEAR;
            end else begin
              row_r    <= nxt_row_s;
              chunk_r  <= nxt_chunk_s;
              o_data_r <= chunk_sel(snap_r[nxt_row_s], nxt_chunk_s);
            end
          end else begin
            o_data_r <= o_data_r;
          end
        end
        ST_CLEAR: begin
          mac_clr_r <= 1'b0;
          done_r    <= 1'b1;
          busy_r    <= 1'b0;
          state_r   <= ST_DONE;
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          o_data_r  <= '0;
          o_valid_r <= 1'b0;
          busy_r    <= 1'b0;
          mac_clr_r <= 1'b0;
          done_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mac_result_unloader.md
Name: mac_result_unloader

Overview:
- Drain side of the matrix-vector MAC array.
- After a computation, snapshots the NUM_ROWS accumulator results, then streams them out as DATA_WIDTH-bit chunks over a valid/ready interface (row 0 first, MS chunk first).
- Then pulses mac_clr for one cycle to zero the MAC accumulators for the next job.
- Sits between the MAC array outputs and the host/UART byte path.

Parameters:
- NUM_ROWS, 8, number of MAC result rows.
- DATA_WIDTH, 8, output chunk width in bits.
- ACC_WIDTH, 24, width of each MAC result; must be an integer multiple of DATA_WIDTH (CHUNKS = ACC_WIDTH/DATA_WIDTH, 3 at defaults).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to capture and send results.
- res_in  input  NUM_ROWS x ACC_WIDTH (unpacked [NUM_ROWS-1:0])  MAC accumulator outputs.
- o_data  output  DATA_WIDTH  current output chunk.
- o_valid  output  1  o_data valid.
- o_ready  input  1  downstream accepts when o_valid & o_ready.
- busy  output  1  high from the capture cycle through the CLEAR state.
- mac_clr  output  1  one-cycle clear pulse to the MAC array.
- done  output  1  one-cycle pulse when the job completes.

Behaviour:
- Reset is asynchronous, active-low; clock is clk. Reset values:
  - State IDLE.
  - o_data=0, o_valid=0, busy=0, mac_clr=0, done=0.
  - Snapshot registers and row/chunk counters = 0.
- States: IDLE, SEND, CLEAR, DONE.
- IDLE:
  - On start=1, res_in[0..NUM_ROWS-1] is latched into snapshot regs on that clock edge.
  - row=0, chunk=0; next state SEND.
  - o_valid rises the cycle after start (latency 1).
  - res_in changes after the capture edge have no effect.
- SEND:
  - o_valid=1; o_data = snapshot[row][ACC_WIDTH-1-chunk*DATA_WIDTH -: DATA_WIDTH] (MS chunk first).
  - A transfer occurs when o_valid & o_ready at a rising edge.
  - On transfer: chunk increments; when chunk==CHUNKS-1, chunk wraps to 0 and row increments.
  - A transfer on row==NUM_ROWS-1, chunk==CHUNKS-1 moves to CLEAR and o_valid drops next cycle.
  - While o_valid=1 and o_ready=0, o_data is held stable; no counter changes.
  - Back-to-back transfers with o_ready held high: one chunk per cycle, NUM_ROWS*CHUNKS cycles total (24 at defaults).
- CLEAR:
  - mac_clr=1 for exactly one cycle, o_valid=0, busy=1.
  - Next state DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0.
  - Next state IDLE.
- busy is 1 in SEND and CLEAR, 0 in IDLE and DONE.
- start while not in IDLE is ignored: no re-capture, no counter change.
- start in the DONE cycle is also ignored; start is accepted only in IDLE.
- o_ready while o_valid=0 is ignored.
- Reset asserted mid-job:
  - Immediate return to IDLE with all outputs at reset values.
  - No mac_clr or done pulse.
  - Partially sent data is abandoned.
- o_data when o_valid=0 is don't-care; the implementation drives 0.
- Results are treated as unsigned bit patterns; no arithmetic is performed.

Test Plan:
- Basic drain:
  - Stimulus: res_in[i] = 24'h010203 + i*24'h111111, pulse start, o_ready held 1.
  - Required: o_valid high for 24 consecutive cycles starting 1 cycle after start.
  - Required byte sequence: 01,02,03,12,13,14,...,78,79,7A.
  - Required: mac_clr pulse 1 cycle later, done pulse 1 cycle after mac_clr, busy 0 afterwards.
- Backpressure:
  - Stimulus: same data, o_ready toggled 1,0,0,1,... (random with a fixed seed).
  - Required: o_data stable while o_valid & !o_ready; the same 24-byte sequence with no duplicates or drops.
  - Required: mac_clr only after the 24th transfer.
- Snapshot isolation:
  - Stimulus: res_in all 24'hAAAAAA at start; change to 24'h555555 the cycle after start.
  - Required: all 24 output bytes are AA.
- Start while busy:
  - Stimulus: second start pulse at transfer 5 and again in the CLEAR cycle.
  - Required: the stream is unaffected, exactly one mac_clr and one done pulse, then IDLE.
  - Follow-up: a new start in IDLE begins a fresh 24-byte job.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously after transfer 10, then release.
  - Required: o_valid, busy, mac_clr and done all 0 immediately; state IDLE; no done pulse.
  - Follow-up: the next start sends all 24 bytes from row 0.
- Boundary values:
  - Stimulus: res_in[7]=24'hFFFFFF, res_in[0]=24'h000000, others 24'h800001.
  - Required: first 3 bytes 00,00,00; rows 1..6 each 80,00,01; last 3 bytes FF,FF,FF.
  - Required: the row and chunk counters wrap correctly at the row-7/chunk-2 boundary.
